// File: rtl/fifo_tx_arbiter.sv
// fifo_tx_arbiter: picks one of NCH source FIFOs, reads one word from it with a
// fixed read latency, hands the word to a byte transmitter and then waits for
// the transmitter to return to idle (or times out) before the next grant.
module fifo_tx_arbiter #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned MODE   = 0,
  parameter int unsigned TO_CYC = 4096
) (
  input  logic                   clk_24m,
  input  logic                   rstn,
  input  logic [NCH-1:0]         ch_empty,
  input  logic [NCH*DW-1:0]      ch_data,
  input  logic                   idle,
  output logic [NCH-1:0]         ch_rden,
  output logic [DW-1:0]          tx_data,
  output logic                   tx_start,
  output logic [$clog2(NCH)-1:0] grant_id,
  output logic                   err_timeout
);

  localparam int unsigned GW  = $clog2(NCH);
  localparam int unsigned WCW = 3;
  localparam int unsigned TCW = $clog2(TO_CYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;

  // synchroniser stages
  logic [NCH-1:0] empty_s1;
  logic [NCH-1:0] empty_s2;
  logic           idle_s1;
  logic           idle_s2;
  logic           idle_prev;
  logic           idle_rise;

  // arbitration
  logic [NCH-1:0] req;
  logic           found;
  logic [NCH-1:0] rot_fp;
  logic [GW-1:0]  pick_fp;
  logic           hit_fp;
  logic [NCH-1:0] rot_rr;
  logic [GW-1:0]  pick_rr;
  logic           hit_rr;
  int unsigned    rr_idx;
  logic [GW-1:0]  pick;

  // FSM and datapath registers
  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [GW-1:0]  gnt;
  logic [GW-1:0]  gnt_nxt;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wcnt_nxt;
  logic [TCW-1:0] tcnt;
  logic [TCW-1:0] tcnt_nxt;
  logic [NCH-1:0] rden_nxt;
  logic [DW-1:0]  tx_data_nxt;
  logic           tx_start_nxt;
  logic [GW-1:0]  grant_id_nxt;
  logic           err_nxt;

  // Bring the asynchronous empty flags and transmitter idle into clk_24m.
  // Empty resets to 1 and idle to 0 so nothing is granted until both stages fill.
  always_ff @(posedge clk_24m or negedge rstn) begin
    if (!rstn) begin
      empty_s1  <= '1;
      empty_s2  <= '1;
      idle_s1   <= 1'b0;
      idle_s2   <= 1'b0;
      idle_prev <= 1'b0;
    end else begin
      empty_s1  <= ch_empty;
      empty_s2  <= empty_s1;
      idle_s1   <= idle;
      idle_s2   <= idle_s1;
      idle_prev <= idle_s2;
    end
  end

  assign idle_rise = idle_s2 & ~idle_prev;
  assign req       = ~empty_s2;
  assign found     = |req;

  // Fixed priority: lowest-index requesting channel.
  always_comb begin
    rot_fp  = '0;
    pick_fp = '0;
    hit_fp  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      rot_fp = req >> i;
      if (!hit_fp && rot_fp[0]) begin
        hit_fp  = 1'b1;
        pick_fp = GW'(i);
      end
    end
  end

  // Round robin: search upward from the channel after the last grant, wrapping.
  always_comb begin
    rot_rr  = '0;
    pick_rr = '0;
    hit_rr  = 1'b0;
    rr_idx  = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      rr_idx = (32'(gnt) + k) % NCH;
      rot_rr = req >> rr_idx;
      if (!hit_rr && rot_rr[0]) begin
        hit_rr  = 1'b1;
        pick_rr = GW'(rr_idx);
      end
    end
  end

  assign pick = (MODE == 0) ? pick_fp : pick_rr;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    wcnt_nxt     = wcnt;
    tcnt_nxt     = tcnt;
    rden_nxt     = '0;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    grant_id_nxt = grant_id;
    err_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (idle_s2 && found) begin
          gnt_nxt   = pick;
          rden_nxt  = NCH'(1) << pick;
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        // read enable was raised on entry; skip WAIT when data arrives next cycle
        wcnt_nxt  = '0;
        state_nxt = (RD_LAT > 1) ? S_WAIT : S_LOAD;
      end
      S_WAIT: begin
        if (wcnt == WCW'(RD_LAT - 2)) begin
          state_nxt = S_LOAD;
        end else begin
          wcnt_nxt = wcnt + WCW'(1);
        end
      end
      S_LOAD: begin
        tx_data_nxt  = DW'(ch_data >> (32'(gnt) * DW));
        tx_start_nxt = 1'b1;
        grant_id_nxt = gnt;
        tcnt_nxt     = '0;
        state_nxt    = S_SEND;
      end
      S_SEND: begin
        // a transmitter return on the terminal cycle takes precedence over the timeout
        if (idle_rise) begin
          state_nxt = S_IDLE;
        end else if (tcnt == TCW'(TO_CYC - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tcnt_nxt = tcnt + TCW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_24m or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      gnt         <= GW'(NCH - 1);
      wcnt        <= '0;
      tcnt        <= '0;
      ch_rden     <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      wcnt        <= wcnt_nxt;
      tcnt        <= tcnt_nxt;
      ch_rden     <= rden_nxt;
      tx_data     <= tx_data_nxt;
      tx_start    <= tx_start_nxt;
      grant_id    <= grant_id_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Bench for fifo_tx_arbiter: instance a is fixed priority with RD_LAT=3,
// instance b is round robin with RD_LAT=2; both use a 16-cycle SEND timeout.
module tb_fifo_tx_arbiter;

  localparam int LAT_A = 3;
  localparam int LAT_B = 2;
  localparam int TOC   = 16;
  localparam logic [23:0] STAT = 24'hC2B1A0;

  typedef struct packed {
    logic [1:0] gnt;
    logic       dyn;
    logic [7:0] data;
  } exp_t;

  logic        clk_24m = 1'b0;
  logic        rstn;
  logic [2:0]  ch_empty    [2];
  logic [23:0] ch_data     [2];
  logic        idle        [2];
  logic [2:0]  ch_rden     [2];
  logic [7:0]  tx_data     [2];
  logic        tx_start    [2];
  logic [1:0]  grant_id    [2];
  logic        err_timeout [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   tx_cnt [2];
  int   tx_cyc [2];
  int   err_cnt[2];
  int   err_cyc[2];
  int   rden_t [2];
  int   rden_cnt[2];
  bit   pend   [2];
  bit   dyn    [2];
  logic [2:0] prev_rd[2];
  logic       prev_er[2];

  fifo_tx_arbiter #(.NCH(3), .DW(8), .RD_LAT(LAT_A), .MODE(0), .TO_CYC(TOC)) dut_a (
    .clk_24m(clk_24m), .rstn(rstn), .ch_empty(ch_empty[0]), .ch_data(ch_data[0]),
    .idle(idle[0]), .ch_rden(ch_rden[0]), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
    .grant_id(grant_id[0]), .err_timeout(err_timeout[0])
  );

  fifo_tx_arbiter #(.NCH(3), .DW(8), .RD_LAT(LAT_B), .MODE(1), .TO_CYC(TOC)) dut_b (
    .clk_24m(clk_24m), .rstn(rstn), .ch_empty(ch_empty[1]), .ch_data(ch_data[1]),
    .idle(idle[1]), .ch_rden(ch_rden[1]), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
    .grant_id(grant_id[1]), .err_timeout(err_timeout[1])
  );

  always #20 clk_24m = ~clk_24m;

  always @(posedge clk_24m) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // channel byte that changes every cycle, so only the sampled cycle matches
  function automatic logic [7:0] fdyn(input int ch, input int c);
    return {2'(ch), 6'(c)};
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int d, input logic [1:0] g, input bit dy);
    exp_t e;
    e.gnt  = g;
    e.dyn  = dy;
    e.data = 8'(STAT >> (32'(g) * 8));
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic qpop(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  task automatic mon(input int d);
    exp_t  e;
    string n;
    int    lat;
    n   = (d == 0) ? "a" : "b";
    lat = (d == 0) ? LAT_A : LAT_B;
    if (!rstn) begin
      pend[d]    = 1'b0;
      prev_rd[d] = 3'b000;
      prev_er[d] = 1'b0;
      return;
    end
    if (ch_rden[d] != 3'b000) begin
      rden_cnt[d]++;
      check({n, ".rden_width"}, 32'(prev_rd[d]), 32'd0);
      if (qsize(d) == 0) begin
        check({n, ".rden_unexp"}, 32'(qsize(d) != 0), 32'd1);
      end else begin
        e = qfront(d);
        check({n, ".rden_ch"}, 32'(ch_rden[d]), 32'(3'b001 << e.gnt));
        rden_t[d] = cyc;
        pend[d]   = 1'b1;
      end
    end
    prev_rd[d] = ch_rden[d];
    if (tx_start[d]) begin
      tx_cnt[d]++;
      tx_cyc[d] = cyc;
      if (!pend[d] || qsize(d) == 0) begin
        check({n, ".tx_unexp"}, 32'(pend[d]), 32'd1);
      end else begin
        qpop(d, e);
        pend[d] = 1'b0;
        check({n, ".lat"}, 32'(cyc - rden_t[d]), 32'(lat + 1));
        check({n, ".data"}, 32'(tx_data[d]),
              32'(e.dyn ? fdyn(int'(e.gnt), rden_t[d] + lat) : e.data));
        check({n, ".gid"}, 32'(grant_id[d]), 32'(e.gnt));
      end
    end
    if (err_timeout[d]) begin
      check({n, ".err_width"}, 32'(prev_er[d]), 32'd0);
      err_cnt[d]++;
      err_cyc[d] = cyc;
    end
    prev_er[d] = err_timeout[d];
  endtask

  // drive channel data and watch both instances away from the active edge
  always @(negedge clk_24m) begin
    for (int d = 0; d < 2; d++) begin
      if (dyn[d]) begin
        for (int i = 0; i < 3; i++) ch_data[d][i*8 +: 8] = fdyn(i, cyc);
      end else begin
        ch_data[d] = STAT;
      end
      mon(d);
    end
  end

  task automatic wait_tx(input int d, input int n0);
    int k;
    k = 0;
    while (tx_cnt[d] <= n0 && k < 80) begin
      @(negedge clk_24m);
      k++;
    end
    check((d == 0) ? "a.tx_seen" : "b.tx_seen", 32'(tx_cnt[d] > n0), 32'd1);
  endtask

  task automatic handshake(input int d);
    idle[d] = 1'b0;
    repeat (3) @(negedge clk_24m);
    idle[d] = 1'b1;
    @(negedge clk_24m);
  endtask

  task automatic chk_zero(input int d, input string n);
    check({n, ".rst_rden"},  32'(ch_rden[d]),     32'd0);
    check({n, ".rst_data"},  32'(tx_data[d]),     32'd0);
    check({n, ".rst_start"}, 32'(tx_start[d]),    32'd0);
    check({n, ".rst_gid"},   32'(grant_id[d]),    32'd0);
    check({n, ".rst_err"},   32'(err_timeout[d]), 32'd0);
  endtask

  initial begin
    int n0;
    int e0;
    int r0;
    int t1;
    int t2;
    int k;
    rstn        = 1'b0;
    idle[0]     = 1'b0;
    idle[1]     = 1'b0;
    ch_empty[0] = 3'b111;
    ch_empty[1] = 3'b111;
    dyn[0]      = 1'b0;
    dyn[1]      = 1'b0;
    repeat (3) @(negedge clk_24m);
    chk_zero(0, "a");
    chk_zero(1, "b");
    rstn = 1'b1;
    repeat (3) @(negedge clk_24m);

    // fixed priority with every channel non-empty: channel 0 always wins
    for (int j = 0; j < 3; j++) begin
      n0 = tx_cnt[0];
      qpush(0, 2'd0, 1'b0);
      if (j == 0) begin
        idle[0]     = 1'b1;
        ch_empty[0] = 3'b000;
      end
      wait_tx(0, n0);
      if (j == 2) ch_empty[0] = 3'b111;
      handshake(0);
    end
    repeat (4) @(negedge clk_24m);

    // single channel 1 request, data sampled at the read-latency cycle
    dyn[0] = 1'b1;
    n0 = tx_cnt[0];
    qpush(0, 2'd1, 1'b1);
    ch_empty[0] = 3'b101;
    wait_tx(0, n0);
    ch_empty[0] = 3'b111;
    handshake(0);
    dyn[0] = 1'b0;
    repeat (4) @(negedge clk_24m);

    // SEND timeout with idle held high, then an immediate regrant
    n0 = tx_cnt[0];
    qpush(0, 2'd2, 1'b0);
    ch_empty[0] = 3'b011;
    wait_tx(0, n0);
    t1 = tx_cyc[0];
    n0 = tx_cnt[0];
    qpush(0, 2'd2, 1'b0);
    e0 = err_cnt[0];
    k = 0;
    while (err_cnt[0] == e0 && k < 40) begin
      @(negedge clk_24m);
      k++;
    end
    check("a.err_seen", 32'(err_cnt[0] - e0), 32'd1);
    check("a.err_gap", 32'(err_cyc[0] - t1), 32'(TOC));
    wait_tx(0, n0);

    // idle_rise landing on the terminal count: no error, normal return
    t2 = tx_cyc[0];
    n0 = tx_cnt[0];
    qpush(0, 2'd2, 1'b0);
    e0 = err_cnt[0];
    while (cyc < t2 + 10) @(negedge clk_24m);
    idle[0] = 1'b0;
    while (cyc < t2 + 13) @(negedge clk_24m);
    idle[0] = 1'b1;
    wait_tx(0, n0);
    check("a.err_none", 32'(err_cnt[0] - e0), 32'd0);
    ch_empty[0] = 3'b111;
    handshake(0);
    repeat (4) @(negedge clk_24m);

    // round robin with every channel non-empty: 0,1,2,0
    for (int j = 0; j < 4; j++) begin
      n0 = tx_cnt[1];
      qpush(1, 2'(j % 3), 1'b0);
      if (j == 0) begin
        idle[1]     = 1'b1;
        ch_empty[1] = 3'b000;
      end
      wait_tx(1, n0);
      if (j == 3) ch_empty[1] = 3'b111;
      handshake(1);
    end
    repeat (4) @(negedge clk_24m);

    // transmitter busy: requests pending but no grant until idle returns
    idle[1] = 1'b0;
    repeat (3) @(negedge clk_24m);
    ch_empty[1] = 3'b000;
    r0 = rden_cnt[1];
    n0 = tx_cnt[1];
    repeat (12) @(negedge clk_24m);
    check("b.busy_rden", 32'(rden_cnt[1] - r0), 32'd0);
    check("b.busy_tx", 32'(tx_cnt[1] - n0), 32'd0);
    qpush(1, 2'd1, 1'b0);
    idle[1] = 1'b1;
    wait_tx(1, n0);
    ch_empty[1] = 3'b111;
    handshake(1);
    repeat (4) @(negedge clk_24m);

    // reset during WAIT abandons the read; new grant only after resync
    qpush(0, 2'd0, 1'b0);
    ch_empty[0] = 3'b110;
    k = 0;
    while (ch_rden[0] == 3'b000 && k < 30) begin
      @(negedge clk_24m);
      k++;
    end
    check("a.rd_seen", 32'(k < 30), 32'd1);
    @(negedge clk_24m);
    rstn = 1'b0;
    #1;
    chk_zero(0, "a_mid");
    chk_zero(1, "b_mid");
    q0.delete();
    repeat (2) @(negedge clk_24m);
    n0 = tx_cnt[0];
    qpush(0, 2'd0, 1'b0);
    rstn = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_24m);
      check("a.fill_rden", 32'(ch_rden[0]), 32'd0);
    end
    wait_tx(0, n0);
    ch_empty[0] = 3'b111;
    handshake(0);
    repeat (6) @(negedge clk_24m);
    check("q_left", 32'(q0.size() + q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_tx_arbiter.md
FIFO_TX_ARBITER -- requirements
Module: fifo_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NCH, default 3, number of source FIFO channels (2..8).
REQ-002 The block SHALL have parameter DW, default 8, data width per channel.
REQ-003 The block SHALL have parameter RD_LAT, default 2, cycles from ch_rden high to valid ch_data (1..4).
REQ-004 The block SHALL have parameter MODE, default 0, arbitration mode: 0 fixed priority, 1 round robin.
REQ-005 The block SHALL have parameter TO_CYC, default 4096, SEND timeout in clk_24m cycles (≥16).
REQ-006 The block SHALL have port clk_24m  input  1  sole clock.
REQ-007 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have port ch_empty  input  NCH  per-channel FIFO empty flag, asynchronous to the arbiter.
REQ-009 The block SHALL have port ch_data  input  NCH*DW  channel data; channel i occupies bits [i*DW+DW-1:i*DW].
REQ-010 The block SHALL have port idle  input  1  transmitter idle, high = ready, asynchronous.
REQ-011 The block SHALL have port ch_rden  output  NCH  per-channel FIFO read enable, at most one bit high.
REQ-012 The block SHALL have port tx_data  output  DW  byte handed to the transmitter.
REQ-013 The block SHALL have port tx_start  output  1  one-cycle pulse, tx_data valid.
REQ-014 The block SHALL have port grant_id  output  clog2(NCH)  index of the channel last granted.
REQ-015 The block SHALL have port err_timeout  output  1  one-cycle pulse when SEND times out.

Function
REQ-016 ch_empty bits SHALL pass two-flop synchronisers (reset 1); idle SHALL pass a two-flop synchroniser (reset 0); idle_rise = synced idle high and its previous value low.
REQ-017 FSM states SHALL be IDLE, RD, WAIT, LOAD, SEND.
REQ-018 IDLE: when synced idle = 1 and any synced ch_empty = 0, the arbiter SHALL grant one channel and go to RD; otherwise it SHALL stay in IDLE.
REQ-019 MODE 0: the lowest-index non-empty channel SHALL win.
REQ-020 MODE 1: the search SHALL start at (last grant + 1) mod NCH and wrap; last grant resets to NCH-1 so channel 0 is first.
REQ-021 RD: ch_rden[grant] SHALL be high for exactly one cycle; the FSM then goes to WAIT.
REQ-022 WAIT: the FSM SHALL count RD_LAT-1 cycles (0 cycles if RD_LAT = 1) and then go to LOAD.
REQ-023 LOAD: tx_data SHALL capture the granted ch_data slice, tx_start SHALL pulse high for one cycle, grant_id SHALL update, and the FSM goes to SEND.
REQ-024 Overall latency from RD entry to the tx_start pulse SHALL be RD_LAT+1 cycles.
REQ-025 SEND: on idle_rise the FSM SHALL return to IDLE; idle_rise in any other state SHALL be ignored.
REQ-026 SEND timeout: a counter cleared on LOAD SHALL, after TO_CYC cycles without idle_rise, pulse err_timeout and return to IDLE; if idle_rise coincides with the terminal count, idle_rise wins and no error pulse is produced.
REQ-027 tx_data SHALL hold its value outside LOAD.
REQ-028 ch_empty changing after the grant SHALL NOT abort the read; underflow protection is the FIFO's responsibility.
REQ-029 If synced idle is low in IDLE, no grant SHALL occur even when channels are non-empty.

Reset
REQ-030 On rstn low, all outputs SHALL go to 0 immediately: ch_rden = 0, tx_data = 0, tx_start = 0, grant_id = 0, err_timeout = 0.
REQ-031 On rstn low, the state SHALL go to IDLE, the counters SHALL clear, and last grant SHALL be NCH-1.
REQ-032 Reset asserted mid-operation (in any state) SHALL abandon the transfer; after release, the block SHALL wait at least 2 cycles (synchroniser fill) before any grant.

Verification
REQ-033 MODE 0, idle = 1, ch_empty = 3'b000, data 0xA0/0xB1/0xC2, idle pulsed low then high after each tx_start -> tx_data sequence 0xA0, 0xA0, ... (only ch0 is served while it is non-empty).
REQ-034 MODE 1, all channels continuously non-empty, idle handshake after each byte -> grant_id sequence 0, 1, 2, 0; each ch_rden bit is exactly one cycle wide.
REQ-035 RD_LAT = 3, single ch1 request -> ch_rden[1] at cycle t, tx_start at t+4, tx_data = ch1 data as presented at t+3.
REQ-036 TO_CYC = 16, idle held high in SEND -> err_timeout pulses 16 cycles after LOAD, FSM returns to IDLE, and the next grant occurs.
REQ-037 rstn asserted during WAIT -> ch_rden, tx_start and tx_data are 0 within the same cycle; no tx_start pulse follows after release until a new grant.
